hamming_window_acc: RTL and testbench

//  Downstream stage of hamming_dist. Accumulates the per-sample Hamming distance over a

---
 rtl/hamming_window_acc.sv | 98 +++++++++
 tb/tb_hamming_window_acc.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hamming_window_acc.sv
// Sums per-sample Hamming distance over a window of WIN valid samples.
// Define HAMM_ACC_SAT_EN to saturate the accumulator instead of wrapping.
module hamming_window_acc #(
  parameter int DIST_W = 3,
  parameter int WIN    = 8,
  parameter int SUM_W  = 6,
  parameter int THRESH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIST_W-1:0] dist_in,
  input  logic              dist_valid,
  output logic              busy,
  output logic              done,
  output logic [SUM_W-1:0]  sum_out,
  output logic              over_thresh
);

  localparam int CNT_W = $clog2(WIN);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [SUM_W-1:0] acc, acc_nxt, acc_add;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SUM_W:0]   sum_wide;
  logic             last;

  assign sum_wide = {1'b0, acc} + (SUM_W+1)'(dist_in);

`ifdef HAMM_ACC_SAT_EN
  assign acc_add = sum_wide[SUM_W] ? '1 : sum_wide[SUM_W-1:0];
`else
  assign acc_add = sum_wide[SUM_W-1:0];
`endif

  assign last = (state == ACC) && dist_valid
             && (cnt == CNT_W'(WIN - 1));

  assign busy = (state == ACC);
  assign done = (state == DONE);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACC;
          acc_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ACC: begin
        if (dist_valid) begin
          acc_nxt = acc_add;
          cnt_nxt = cnt + 1'b1;
          if (last) begin
            state_nxt = DONE;
            cnt_nxt   = '0;
          end
        end
      end
      DONE: begin
        acc_nxt = '0;
        cnt_nxt = '0;
        // back-to-back windows skip IDLE entirely
        state_nxt = start ? ACC : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      sum_out     <= '0;
      over_thresh <= 1'b0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
      if (last) begin
        sum_out     <= acc_add;
        over_thresh <= 32'(acc_add) > THRESH;
      end
    end
  end

endmodule

// File: tb/tb_hamming_window_acc.sv
// Scoreboard bench for hamming_window_acc.
// Runs a 6-bit and a 4-bit accumulator instance on shared stimulus.
module tb_hamming_window_acc;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] dist_in;
  logic       dist_valid;

  logic       busy6, done6, ot6;
  logic [5:0] sum6;
  logic       busy4, done4, ot4;
  logic [3:0] sum4;

  hamming_window_acc #(
    .DIST_W(3), .WIN(8), .SUM_W(6), .THRESH(12)
  ) dut6 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dist_in(dist_in), .dist_valid(dist_valid),
    .busy(busy6), .done(done6),
    .sum_out(sum6), .over_thresh(ot6)
  );

  hamming_window_acc #(
    .DIST_W(3), .WIN(8), .SUM_W(4), .THRESH(12)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dist_in(dist_in), .dist_valid(dist_valid),
    .busy(busy4), .done(done4),
    .sum_out(sum4), .over_thresh(ot4)
  );

  typedef struct {
    int s6;
    int o6;
    int s4;
    int o4;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  int m_st  = 0;
  int m_cnt = 0;
  int m_a6  = 0;
  int m_a4  = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int addw(input int a, input int d, input int w);
    int s;
    int mx;
    s  = a + d;
    mx = (1 << w) - 1;
`ifdef HAMM_ACC_SAT_EN
    return (s > mx) ? mx : s;
`else
    return s & mx;
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    if (rst_n && done6) begin
      check("done4_sync", done4, 1);
      if (q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("sum6", sum6, e.s6);
        check("ot6", ot6, e.o6);
        check("sum4", sum4, e.s4);
        check("ot4", ot4, e.o4);
      end
    end
  end

  task automatic cyc(input logic s, input logic v, input int d);
    @(negedge clk);
    check("busy6", busy6, int'(m_st == 1));
    check("busy4", busy4, int'(m_st == 1));
    check("done6", done6, int'(m_st == 2));
    start      = s;
    dist_valid = v;
    dist_in    = 3'(d);
    case (m_st)
      0: begin
        if (s) begin
          m_st = 1; m_cnt = 0; m_a6 = 0; m_a4 = 0;
        end
      end
      1: begin
        if (v) begin
          m_a6 = addw(m_a6, d, 6);
          m_a4 = addw(m_a4, d, 4);
          m_cnt++;
          if (m_cnt == 8) begin
            q.push_back('{m_a6, int'(m_a6 > 12),
                          m_a4, int'(m_a4 > 12)});
            m_st = 2;
          end
        end
      end
      default: begin
        if (s) begin
          m_st = 1; m_cnt = 0; m_a6 = 0; m_a4 = 0;
        end else begin
          m_st = 0;
        end
      end
    endcase
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, busy6, 0);
    check({tag, "_done"}, done6, 0);
    check({tag, "_sum6"}, sum6, 0);
    check({tag, "_ot6"}, ot6, 0);
    check({tag, "_sum4"}, sum4, 0);
    check({tag, "_ot4"}, ot4, 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    check_zero("rst_mid");
    m_st = 0;
    start = 0;
    dist_valid = 0;
    dist_in = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    rst_n = 1;
    start = 0;
    dist_valid = 0;
    dist_in = 0;
    #2 rst_n = 0;
    #1 check_zero("rst_init");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    // basic window, idle valid ignored
    cyc(0, 1, 7);
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 2);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // gapped valid
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 1);
      if (i < 7) cyc(0, 0, 5);
    end
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // start held through ACC, then restart from DONE
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 3);
    cyc(1, 1, 7);
    for (int i = 0; i < 8; i++) cyc(0, 1, i % 2);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // overflow of the narrow instance
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 4);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // mixed values
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, i % 5);
    cyc(0, 0, 0);
    cyc(0, 0, 0);

    // reset mid-window, then fresh window
    cyc(1, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 1, 4);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 1, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);

    check("queue_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
